pip_mem_stage: RTL and testbench

//  Memory-access stage between the EX/MEM register and the MEM/WB register.

---
 rtl/pip_mem_stage.sv | 163 ++++++++++++++++
 tb/tb_pip_mem_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pip_mem_stage.sv
// Memory-access pipeline stage: issues data-memory loads/stores over a req/ready
// handshake, aligns store/load data and stalls upstream while an access is pending.
module pip_mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [31:0] alu_res,
  input  logic [31:0] st_data,
  input  logic [2:0]  funct3,
  input  logic        DMread,
  input  logic        DMwrite,
  input  logic [4:0]  rd_ad,
  input  logic        rdEn,
  input  logic        clr_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ready,
  output logic        stall,
  output logic [31:0] rd_o,
  output logic [4:0]  rd_ad_o,
  output logic        rdEn_o,
  output logic        DMread_o,
  output logic        mis_err,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mis_err_q, mis_err_d;
  logic          bus_err_q, bus_err_d;

  logic        memop;
  logic        misalign;
  logic        illegal_f3;
  logic        mis;
  logic        complete;
  logic        abort;
  logic        gate;
  logic [1:0]  a_lo;
  logic [31:0] shifted;
  logic [31:0] load_val;

  // Access-size decode, byte-lane placement and illegal-access detection.
  always_comb begin
    a_lo       = alu_res[1:0];
    memop      = valid & (DMread | DMwrite);
    illegal_f3 = (funct3[1:0] == 2'b11) | (funct3 == 3'b110);
    misalign   = 1'b0;
    dm_be      = 4'b0000;
    dm_wdata   = st_data;
    case (funct3[1:0])
      2'b00: begin
        dm_be    = 4'b0001 << a_lo;
        dm_wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        dm_be    = 4'b0011 << a_lo;
        dm_wdata = {2{st_data[15:0]}};
        misalign = a_lo[0];
      end
      2'b10: begin
        dm_be    = 4'b1111;
        misalign = (a_lo != 2'b00);
      end
      default: dm_be = 4'b0000;
    endcase
    mis     = memop & (illegal_f3 | misalign | (DMread & DMwrite));
    dm_addr = {alu_res[31:2], 2'b00};
  end

  // Handshake FSM; the counter includes the IDLE issue cycle, so an access that
  // never sees ready stalls for exactly TIMEOUT cycles before aborting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dm_req   = 1'b0;
    stall    = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (memop && !mis) begin
          dm_req = 1'b1;
          if (dm_ready) begin
            complete = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = WAIT;
            cnt_d   = CW'(1);
          end
        end
      end
      WAIT: begin
        dm_req = 1'b1;
        if (dm_ready) begin
          complete = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (cnt_q == TMAX) begin
          abort   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Load alignment and MEM/WB drive; set beats clear on the sticky flags.
  always_comb begin
    shifted = dm_rdata >> {a_lo, 3'b000};
    case (funct3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      default: load_val = dm_rdata;
    endcase
    dm_we     = dm_req & DMwrite;
    gate      = valid & ~stall & ~abort & ~mis;
    rdEn_o    = gate & rdEn;
    DMread_o  = gate & DMread;
    rd_ad_o   = rd_ad;
    rd_o      = (complete && DMread) ? load_val : alu_res;
    mis_err_d = mis | (mis_err_q & ~clr_err);
    bus_err_d = abort | (bus_err_q & ~clr_err);
    mis_err   = mis_err_q;
    bus_err   = bus_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mis_err_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mis_err_q <= mis_err_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_pip_mem_stage.sv
// Directed bench for pip_mem_stage: scoreboard of expected MEM/WB results,
// immediate-assertion checks sampled on the falling clock edge.
module tb_pip_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [31:0] alu_res;
  logic [31:0] st_data;
  logic [2:0]  funct3;
  logic        DMread;
  logic        DMwrite;
  logic [4:0]  rd_ad;
  logic        rdEn;
  logic        clr_err;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        stall;
  logic [31:0] rd_o;
  logic [4:0]  rd_ad_o;
  logic        rdEn_o;
  logic        DMread_o;
  logic        mis_err;
  logic        bus_err;

  typedef struct {
    logic [31:0] rd;
    logic        rden;
    logic        dmread;
    logic [4:0]  rdad;
  } exp_t;

  exp_t sbq[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  pip_mem_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .alu_res(alu_res),
    .st_data(st_data), .funct3(funct3), .DMread(DMread), .DMwrite(DMwrite),
    .rd_ad(rd_ad), .rdEn(rdEn), .clr_err(clr_err), .dm_req(dm_req),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .stall(stall), .rd_o(rd_o),
    .rd_ad_o(rd_ad_o), .rdEn_o(rdEn_o), .DMread_o(DMread_o),
    .mis_err(mis_err), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction and push its expected MEM/WB result.
  task automatic applyStimulus(input logic [2:0] f3, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] st,
                               input logic [31:0] rdata, input logic [4:0] rdad,
                               input logic rden, input logic [31:0] expRd,
                               input logic expRden, input logic expDmread);
    exp_t e;
    valid    = 1'b1;
    funct3   = f3;
    DMread   = rd;
    DMwrite  = wr;
    alu_res  = addr;
    st_data  = st;
    dm_rdata = rdata;
    rd_ad    = rdad;
    rdEn     = rden;
    e.rd     = expRd;
    e.rden   = expRden;
    e.dmread = expDmread;
    e.rdad   = rdad;
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    testsRun++;
    if (sbq.size() == 0) begin
      testsFailed++;
      $error("[TB] FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      testsRun--;
      e = sbq.pop_front();
      check({tag, "_rd_o"}, rd_o, e.rd);
      check({tag, "_rdEn_o"}, {31'b0, rdEn_o}, {31'b0, e.rden});
      check({tag, "_DMread_o"}, {31'b0, DMread_o}, {31'b0, e.dmread});
      check({tag, "_rd_ad_o"}, {27'b0, rd_ad_o}, {27'b0, e.rdad});
    end
  endtask

  // Runs an issued access to completion or abort; readyAfter<0 never raises ready.
  task automatic runAccess(input string tag, input int readyAfter, input int expStalls,
                           input logic [3:0] expBe, input logic expWe,
                           input logic [31:0] expWdata);
    int nstall;
    nstall   = 0;
    dm_ready = (readyAfter == 0);
    @(negedge clk);
    check({tag, "_dm_req"}, {31'b0, dm_req}, 32'd1);
    check({tag, "_dm_addr"}, dm_addr, {alu_res[31:2], 2'b00});
    check({tag, "_dm_be"}, {28'b0, dm_be}, {28'b0, expBe});
    check({tag, "_dm_we"}, {31'b0, dm_we}, {31'b0, expWe});
    if (expWe) check({tag, "_dm_wdata"}, dm_wdata, expWdata);
    for (int i = 0; i < 64; i++) begin
      if (stall !== 1'b1) break;
      if (nstall == 0) check({tag, "_bubble"}, {31'b0, rdEn_o}, 32'd0);
      nstall++;
      nextCycle();
      if (nstall == readyAfter) dm_ready = 1'b1;
      @(negedge clk);
    end
    check({tag, "_stalls"}, nstall, expStalls);
    checkOutput(tag);
    nextCycle();
    valid    = 1'b0;
    DMread   = 1'b0;
    DMwrite  = 1'b0;
    dm_ready = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    valid    = 1'b0;
    alu_res  = 32'h0;
    st_data  = 32'h0;
    funct3   = 3'b010;
    DMread   = 1'b0;
    DMwrite  = 1'b0;
    rd_ad    = 5'd0;
    rdEn     = 1'b0;
    clr_err  = 1'b0;
    dm_rdata = 32'h0;
    dm_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_stall", {31'b0, stall}, 32'd0);
    check("reset_mis_err", {31'b0, mis_err}, 32'd0);
    check("reset_bus_err", {31'b0, bus_err}, 32'd0);
    check("reset_dm_req", {31'b0, dm_req}, 32'd0);
    rst_n = 1'b1;
    nextCycle();

    // Zero-wait word load.
    applyStimulus(3'b010, 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 5'd5, 1'b1,
                  32'hDEADBEEF, 1'b1, 1'b1);
    runAccess("lw_zero_wait", 0, 0, 4'b1111, 1'b0, 32'h0);

    // Signed byte load from the top lane with three wait states.
    applyStimulus(3'b000, 1'b1, 1'b0, 32'h103, 32'h0, 32'h80123456, 5'd6, 1'b1,
                  32'hFFFFFF80, 1'b1, 1'b1);
    runAccess("lb_wait3", 3, 3, 4'b1000, 1'b0, 32'h0);

    applyStimulus(3'b001, 1'b1, 1'b0, 32'h202, 32'h0, 32'h8001AAAA, 5'd7, 1'b1,
                  32'hFFFF8001, 1'b1, 1'b1);
    runAccess("lh_wait1", 1, 1, 4'b1100, 1'b0, 32'h0);

    applyStimulus(3'b101, 1'b1, 1'b0, 32'h202, 32'h0, 32'h8001AAAA, 5'd8, 1'b1,
                  32'h00008001, 1'b1, 1'b1);
    runAccess("lhu", 0, 0, 4'b1100, 1'b0, 32'h0);

    applyStimulus(3'b100, 1'b1, 1'b0, 32'h301, 32'h0, 32'h0000F000, 5'd9, 1'b1,
                  32'h000000F0, 1'b1, 1'b1);
    runAccess("lbu", 2, 2, 4'b0010, 1'b0, 32'h0);

    // Stores: no register write, rd_o carries the address.
    applyStimulus(3'b001, 1'b0, 1'b1, 32'h102, 32'h1234ABCD, 32'h0, 5'd0, 1'b0,
                  32'h102, 1'b0, 1'b0);
    runAccess("sh", 0, 0, 4'b1100, 1'b1, 32'hABCDABCD);

    applyStimulus(3'b000, 1'b0, 1'b1, 32'h401, 32'h000000A5, 32'h0, 5'd0, 1'b0,
                  32'h401, 1'b0, 1'b0);
    runAccess("sb", 2, 2, 4'b0010, 1'b1, 32'hA5A5A5A5);

    // Non-memory instruction passes straight through.
    applyStimulus(3'b000, 1'b0, 1'b0, 32'h12345678, 32'h0, 32'h0, 5'd10, 1'b1,
                  32'h12345678, 1'b1, 1'b0);
    @(negedge clk);
    check("alu_stall", {31'b0, stall}, 32'd0);
    check("alu_dm_req", {31'b0, dm_req}, 32'd0);
    checkOutput("alu");
    nextCycle();

    // Misaligned LHU: no request, bubble, sticky flag; set wins over clear.
    applyStimulus(3'b101, 1'b1, 1'b0, 32'h101, 32'h0, 32'h0, 5'd11, 1'b1,
                  32'h101, 1'b0, 1'b0);
    @(negedge clk);
    check("mis_dm_req", {31'b0, dm_req}, 32'd0);
    check("mis_stall", {31'b0, stall}, 32'd0);
    checkOutput("mis");
    nextCycle();
    clr_err = 1'b1;
    @(negedge clk);
    check("mis_err_set", {31'b0, mis_err}, 32'd1);
    nextCycle();
    valid = 1'b0;
    @(negedge clk);
    check("mis_err_set_priority", {31'b0, mis_err}, 32'd1);
    nextCycle();
    clr_err = 1'b0;
    @(negedge clk);
    check("mis_err_cleared", {31'b0, mis_err}, 32'd0);
    nextCycle();

    // Illegal funct3 store is also rejected.
    applyStimulus(3'b011, 1'b0, 1'b1, 32'h500, 32'h0, 32'h0, 5'd0, 1'b0,
                  32'h500, 1'b0, 1'b0);
    @(negedge clk);
    check("illegal_dm_req", {31'b0, dm_req}, 32'd0);
    checkOutput("illegal");
    nextCycle();
    valid   = 1'b0;
    DMwrite = 1'b0;
    clr_err = 1'b1;
    nextCycle();
    clr_err = 1'b0;

    // Timeout: ready never comes.
    applyStimulus(3'b010, 1'b1, 1'b0, 32'h600, 32'h0, 32'h0, 5'd12, 1'b1,
                  32'h600, 1'b0, 1'b0);
    runAccess("timeout", -1, 16, 4'b1111, 1'b0, 32'h0);
    @(negedge clk);
    check("timeout_bus_err", {31'b0, bus_err}, 32'd1);
    check("timeout_idle_req", {31'b0, dm_req}, 32'd0);
    nextCycle();

    // Reset in the middle of a wait.
    valid   = 1'b1;
    funct3  = 3'b010;
    DMread  = 1'b1;
    alu_res = 32'h700;
    rd_ad   = 5'd13;
    rdEn    = 1'b1;
    repeat (4) nextCycle();
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    check("rst_mid_stall", {31'b0, stall}, 32'd0);
    check("rst_mid_bus_err", {31'b0, bus_err}, 32'd0);
    check("rst_mid_mis_err", {31'b0, mis_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();
    applyStimulus(3'b010, 1'b1, 1'b0, 32'h704, 32'h0, 32'hCAFEF00D, 5'd14, 1'b1,
                  32'hCAFEF00D, 1'b1, 1'b1);
    runAccess("lw_after_rst", 2, 2, 4'b1111, 1'b0, 32'h0);

    check("sb_drained", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
